muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only value 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port flush  input  1  abort current operation; no done is produced.
REQ-006 SHALL have port funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a  input  XLEN  rs1 value (multiplicand/dividend).
REQ-008 SHALL have port op_b  input  XLEN  rs2 value (multiplier/divisor).
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE; core stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid that cycle.
REQ-011 SHALL have port result  output  XLEN  operation result; held until next accepted start or reset.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIN; transitions IDLE->CALC on start&!flush, CALC->FIN after XLEN iterations, FIN->IDLE unconditionally.
REQ-013 SHALL latch funct3, op_a, op_b on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1 (no queueing, no restart).
REQ-015 SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per CALC cycle on magnitudes, iteration counter 0..XLEN-1.
REQ-016 SHALL treat operands per funct3 signedness: MULH both signed, MULHSU op_a signed/op_b unsigned, MULHU/DIVU/REMU unsigned, DIV/REM signed; sign fix-up applied in FIN.
REQ-017 SHALL output low 32 bits of 64-bit product for MUL, high 32 bits for MULH/MULHSU/MULHU.
REQ-018 SHALL truncate signed quotient toward zero; remainder SHALL take the sign of the dividend.
REQ-019 SHALL, for divisor 0: DIV/DIVU result 32'hFFFF_FFFF; REM/REMU result op_a.
REQ-020 SHALL, for DIV/REM with op_a=32'h8000_0000 and op_b=32'hFFFF_FFFF: DIV result 32'h8000_0000, REM result 0.
REQ-021 SHALL assert done and update result in FIN; latency from accepting edge to done-high cycle is XLEN+1 cycles (33).
REQ-022 SHALL, on flush in any non-IDLE state, go to IDLE next edge, keep done=0, leave result unchanged.
REQ-023 SHALL give flush priority over start when both are asserted in IDLE (start not accepted).
REQ-024 SHALL allow a new start to be accepted in the IDLE cycle immediately after FIN (back-to-back throughput XLEN+2 cycles).

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, enter IDLE and set busy=0, done=0, result=0, counter=0, regardless of state.
REQ-026 SHALL, on reset mid-operation, discard the operation with no done pulse.

Configuration
REQ-027 SHALL support macro MULDIV_EARLY_OUT_EN: when defined, divide-by-zero and signed-overflow (REQ-019/020) cases go IDLE->FIN directly, done one cycle after acceptance; when undefined, these cases take full XLEN+1 latency with identical result values.

Verification
REQ-028 SHALL cover: MUL op_a=7, op_b=-3 (32'hFFFF_FFFD) -> done 33 cycles later, result 32'hFFFF_FFEB.
REQ-029 SHALL cover: MULHU op_a=op_b=32'hFFFF_FFFF -> result 32'hFFFF_FFFE; MULH same operands -> result 0.
REQ-030 SHALL cover: DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14.
REQ-031 SHALL cover: DIVU 5/0 -> 32'hFFFF_FFFF, REMU 5/0 -> 5; done at cycle 1 with MULDIV_EARLY_OUT_EN, cycle 33 without.
REQ-032 SHALL cover: flush at CALC iteration 10 -> IDLE next edge, no done, result unchanged; start during CALC ignored.
REQ-033 SHALL cover: rst_n=0 at iteration 20 -> busy=0, done=0, result=0 next edge; subsequent MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring subtract-shift (divide) step per
// CALC cycle on operand magnitudes; sign fix-up is folded into the result
// written when the sequencer enters FIN.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   request an operation (sampled only in IDLE)
//   flush   in   abort the current operation (no done produced)
//   funct3  in   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU select
//   op_a    in   rs1 (multiplicand / dividend)
//   op_b    in   rs2 (multiplier / divisor)
//   busy    out  high whenever the sequencer is not IDLE
//   done    out  one-cycle pulse, result valid in the same cycle
//   result  out  operation result, held until the next completion or reset
//
// Build option: define MULDIV_EARLY_OUT_EN to finish divide-by-zero and
// signed-overflow divides in a single cycle (IDLE->FIN).
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_op;
  logic [PW-1:0]   r_acc;    // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0] r_mcand;  // multiplicand or divisor magnitude
  logic [XLEN-1:0] r_opa;    // raw dividend, returned by REM/REMU on divide-by-zero
  logic            r_a_neg;
  logic            r_b_neg;
  logic            r_dz;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // Operand decode for the acceptance edge
  logic            w_is_div;
  logic            w_sign_a;
  logic            w_sign_b;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_dz;
  logic            w_ovf;
  logic            w_early;
  logic            w_accept;
  logic            w_last;

  // Iteration datapath
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [PW-1:0]   w_mul_nxt;
  logic [PW-1:0]   w_div_nxt;
  logic [PW-1:0]   w_acc_step;
  logic [XLEN-1:0] w_res_calc;
  logic [XLEN-1:0] w_res_early;

  // Converts raw magnitude result into the architectural result, incl. corner cases
  function automatic logic [XLEN-1:0] f_fixup(
    input logic [PW-1:0]   acc,
    input logic [2:0]      op,
    input logic            a_neg,
    input logic            b_neg,
    input logic            dz,
    input logic            ovf,
    input logic [XLEN-1:0] opa
  );
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    prod = (a_neg ^ b_neg) ? -acc : acc;
    quo  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = a_neg ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
    if (op[2]) begin
      if (dz)          f_fixup = op[1] ? opa : {XLEN{1'b1}};
      else if (ovf)    f_fixup = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      else             f_fixup = op[1] ? rem : quo;
    end else begin
      f_fixup = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    end
  endfunction

  // Signedness: MUL/MULH/MULHSU/DIV/REM treat rs1 signed; MUL/MULH/DIV/REM treat rs2 signed
  always_comb begin
    w_is_div = funct3[2];
    w_sign_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    w_sign_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    w_a_neg  = w_sign_a & op_a[XLEN-1];
    w_b_neg  = w_sign_b & op_b[XLEN-1];
    w_a_mag  = w_a_neg ? -op_a : op_a;
    w_b_mag  = w_b_neg ? -op_b : op_b;
    w_dz     = w_is_div & (op_b == '0);
    w_ovf    = w_is_div & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == {XLEN{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
    w_early  = w_dz | w_ovf;
`else
    w_early  = 1'b0;
`endif
    w_accept = start & ~flush;
    w_last   = (r_cnt == CNT_W'(XLEN - 1));
  end

  // One multiply step (shift-add) and one divide step (restoring) per cycle
  always_comb begin
    w_sum      = {1'b0, r_acc[PW-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_mul_nxt  = {w_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = {r_acc[PW-1:XLEN], r_acc[XLEN-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_mcand});
    w_sub      = w_rem_sh[XLEN-1:0] - r_mcand;
    w_div_nxt  = {(w_ge ? w_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    w_acc_step = r_op[2] ? w_div_nxt : w_mul_nxt;
    w_res_calc = f_fixup(w_acc_step, r_op, r_a_neg, r_b_neg, r_dz, r_ovf, r_opa);
    w_res_early = f_fixup('0, funct3, w_a_neg, w_b_neg, w_dz, w_ovf, op_a);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_early ? S_FIN : S_CALC;
      S_CALC: begin
        if (flush)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_opa    <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_FIN);
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (w_accept) begin
          r_op    <= funct3;
          r_acc   <= {{XLEN{1'b0}}, w_a_mag};
          r_mcand <= w_b_mag;
          r_opa   <= op_a;
          r_a_neg <= w_a_neg;
          r_b_neg <= w_b_neg;
          r_dz    <= w_dz;
          r_ovf   <= w_ovf;
          if (w_early) r_result <= w_res_early;
        end
      end else if (r_state == S_CALC && !flush) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_acc_step;
        if (w_last) r_result <= w_res_calc;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results and latencies,
// input-latching, start-while-busy, flush and mid-operation reset scenarios.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;
  logic [31:0] exp_last;
  int lat_special;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, poke start mid-CALC, measure latency
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f3; op_a = ~a; op_b = ~b;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 60) begin
      if (lat == 5) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'h1234_5678; op_b = 32'h9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    exp_last = exp_res;
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_last = '0;
`ifdef MULDIV_EARLY_OUT_EN
    lat_special = 1;
`else
    lat_special = 33;
`endif
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7_m3",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu_ff",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh_ff",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu_ff",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_7_m2",    3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",    3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("divu_100_7",  3'b101, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu_100_7",  3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_op("divu_5_0",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, lat_special);
    run_op("remu_5_0",    3'b111, 32'd5,         32'd0,         32'd5,         lat_special);
    run_op("div_m7_0",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, lat_special);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat_special);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         lat_special);

    // Flush in CALC at iteration 10
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_result", result, exp_last);
    wait_quiet("flush_no_done", 40);
    chk("flush_result_held", result, exp_last);

    // Flush wins over start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    wait_quiet("flush_start_no_done", 40);

    // Reset at iteration 20
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    rst_n = 1'b1;
    wait_quiet("midrst_no_done", 40);
    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
